// File: rtl/ppm_accum_correlator_if.sv
// rtl/ppm_accum_correlator_if.sv - chip input and symbol decision bundle for ppm_accum_correlator
//
// Purpose: groups the slot-count input stream and the per-symbol decision
// outputs of the PPM correlator into one interface.
// Signals:
//   frame_start     - resynchronise slot/rep counters to 0 (source -> correlator)
//   chip_valid      - chip_in holds the count for the current slot
//   chip_in         - unsigned slot count, CHIP_BITS wide
//   corr_threshold  - minimum accumulated peak, ACC_BITS wide
//   sym_valid       - one-cycle pulse, decision fields are new (correlator -> sink)
//   symbol          - winning slot index
//   peak_value      - accumulated count of the winning slot
//   threshold_unmet - peak_value < corr_threshold
//   tie             - two or more slots share the peak
// Modports: master drives the chip side, slave is the correlator.

interface ppm_accum_correlator_if #(
    parameter int PPM_BITS  = 4,
    parameter int CHIP_BITS = 1,
    parameter int ACC_BITS  = 1
);
    logic                 frame_start;
    logic                 chip_valid;
    logic [CHIP_BITS-1:0] chip_in;
    logic [ACC_BITS-1:0]  corr_threshold;
    logic                 sym_valid;
    logic [PPM_BITS-1:0]  symbol;
    logic [ACC_BITS-1:0]  peak_value;
    logic                 threshold_unmet;
    logic                 tie;

    modport master (
        output frame_start, chip_valid, chip_in, corr_threshold,
        input  sym_valid, symbol, peak_value, threshold_unmet, tie
    );

    modport slave (
        input  frame_start, chip_valid, chip_in, corr_threshold,
        output sym_valid, symbol, peak_value, threshold_unmet, tie
    );
endinterface

// File: rtl/ppm_accum_correlator.sv
// rtl/ppm_accum_correlator.sv - streaming M-ary PPM demodulator with multi-frame accumulation
//
// Purpose: accepts one slot count per valid cycle, accumulates counts over
// REPS frames of the same symbol, tracks the peak slot with a running compare
// during the final frame and registers one decision per symbol.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - ppm_accum_correlator_if.slave (chip input, decision outputs)
// Parameters: PPM_BITS (log2 slots per frame), CHIP_BITS (slot count width),
// REPS (frames accumulated per symbol, >= 1).

module ppm_accum_correlator #(
    parameter int PPM_BITS  = 4,
    parameter int CHIP_BITS = 1,
    parameter int REPS      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    ppm_accum_correlator_if.slave   bus
);
    localparam int ACC_BITS = CHIP_BITS + $clog2(REPS);
    localparam int M        = 1 << PPM_BITS;
    localparam int REP_BITS = (REPS > 1) ? $clog2(REPS) : 1;

    localparam logic [REP_BITS-1:0] LAST_REP  = REP_BITS'(REPS - 1);
    localparam logic [PPM_BITS-1:0] LAST_SLOT = '1;

    logic [PPM_BITS-1:0] s_q;
    logic [REP_BITS-1:0] r_q;
    logic [ACC_BITS-1:0] acc [M];

    // Running peak of the final frame
    logic [ACC_BITS-1:0] best_q;
    logic [PPM_BITS-1:0] idx_q;
    logic                tie_q;

    logic                sym_valid_q;
    logic [PPM_BITS-1:0] symbol_q;
    logic [ACC_BITS-1:0] peak_q;
    logic                unmet_q;
    logic                tie_out_q;

    logic [PPM_BITS-1:0] s_eff;
    logic [REP_BITS-1:0] r_eff;
    logic [ACC_BITS-1:0] sum;
    logic                last_rep;
    logic                last_slot;
    logic [ACC_BITS-1:0] cmp_best;
    logic [PPM_BITS-1:0] cmp_idx;
    logic                cmp_tie;

    // frame_start makes the current chip slot 0 of rep 0, so the counters
    // are replaced before they feed the accumulator and the compare.
    always_comb begin
        s_eff     = bus.frame_start ? '0 : s_q;
        r_eff     = bus.frame_start ? '0 : r_q;
        last_rep  = (r_eff == LAST_REP);
        last_slot = (s_eff == LAST_SLOT);
        // rep 0 overwrites, so stale contents from the previous symbol never leak in
        sum       = ((r_eff == '0) ? '0 : acc[s_eff]) + ACC_BITS'(bus.chip_in);
    end

    // Running compare; the higher slot index wins a tie because slots arrive in order.
    always_comb begin
        cmp_best = best_q;
        cmp_idx  = idx_q;
        cmp_tie  = tie_q;
        if (s_eff == '0) begin
            cmp_best = sum;
            cmp_idx  = '0;
            cmp_tie  = 1'b0;
        end else if (sum > best_q) begin
            cmp_best = sum;
            cmp_idx  = s_eff;
            cmp_tie  = 1'b0;
        end else if (sum == best_q) begin
            cmp_idx  = s_eff;
            cmp_tie  = 1'b1;
        end
    end

    // Accumulator contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (bus.chip_valid) begin
            acc[s_eff] <= sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            r_q         <= '0;
            best_q      <= '0;
            idx_q       <= '0;
            tie_q       <= 1'b0;
            sym_valid_q <= 1'b0;
            symbol_q    <= '0;
            peak_q      <= '0;
            unmet_q     <= 1'b0;
            tie_out_q   <= 1'b0;
        end else begin
            sym_valid_q <= 1'b0;
            if (bus.chip_valid) begin
                if (last_slot) begin
                    s_q <= '0;
                    r_q <= last_rep ? '0 : r_eff + REP_BITS'(1);
                end else begin
                    s_q <= s_eff + PPM_BITS'(1);
                    r_q <= r_eff;
                end
                if (last_rep) begin
                    best_q <= cmp_best;
                    idx_q  <= cmp_idx;
                    tie_q  <= cmp_tie;
                    if (last_slot) begin
                        sym_valid_q <= 1'b1;
                        symbol_q    <= cmp_idx;
                        peak_q      <= cmp_best;
                        unmet_q     <= (cmp_best < bus.corr_threshold);
                        tie_out_q   <= cmp_tie;
                    end
                end
            end else if (bus.frame_start) begin
                s_q <= '0;
                r_q <= '0;
            end
        end
    end

    assign bus.sym_valid       = sym_valid_q;
    assign bus.symbol          = symbol_q;
    assign bus.peak_value      = peak_q;
    assign bus.threshold_unmet = unmet_q;
    assign bus.tie             = tie_out_q;

endmodule

// File: tb/tb_ppm_accum_correlator.sv
// tb/tb_ppm_accum_correlator.sv - scoreboard bench for ppm_accum_correlator (REPS=1 and REPS=4 instances)

module tb_ppm_accum_correlator;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ppm_accum_correlator_if #(.PPM_BITS(4), .CHIP_BITS(1), .ACC_BITS(1)) bus_a ();
    ppm_accum_correlator_if #(.PPM_BITS(4), .CHIP_BITS(2), .ACC_BITS(4)) bus_b ();

    ppm_accum_correlator #(.PPM_BITS(4), .CHIP_BITS(1), .REPS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    ppm_accum_correlator #(.PPM_BITS(4), .CHIP_BITS(2), .REPS(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        int symbol;
        int peak;
        int unmet;
        int tie;
        int cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   stim[4][16];

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input int which, input bit v, input int chip, input bit fs);
        if (which == 0) begin
            bus_a.chip_valid  = v;
            bus_a.chip_in     = 1'(chip);
            bus_a.frame_start = fs;
        end else begin
            bus_b.chip_valid  = v;
            bus_b.chip_in     = 2'(chip);
            bus_b.frame_start = fs;
        end
    endtask

    task automatic clear_stim();
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 16; s++)
                stim[r][s] = 0;
    endtask

    // Drives one full symbol from stim[][], computing the expected decision
    // from whole-symbol slot totals and queueing it with its expected cycle.
    task automatic send(input int which, input int reps, input int thr,
                        input int max_gap, input bit fs_first);
        int   sums[16];
        int   best;
        int   nbest;
        exp_t e;
        best  = -1;
        nbest = 0;
        e.symbol = 0;
        for (int s = 0; s < 16; s++) begin
            sums[s] = 0;
            for (int r = 0; r < reps; r++) sums[s] += stim[r][s];
        end
        for (int s = 0; s < 16; s++) begin
            if (sums[s] > best) begin
                best = sums[s];
                nbest = 1;
                e.symbol = s;
            end else if (sums[s] == best) begin
                nbest++;
                e.symbol = s;
            end
        end
        e.peak  = best;
        e.tie   = (nbest > 1) ? 1 : 0;
        e.unmet = (best < thr) ? 1 : 0;
        if (which == 0) bus_a.corr_threshold = 1'(thr);
        else            bus_b.corr_threshold = 4'(thr);
        for (int r = 0; r < reps; r++) begin
            for (int s = 0; s < 16; s++) begin
                int gap;
                gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                drive(which, 1'b1, stim[r][s], fs_first && r == 0 && s == 0);
                @(posedge clk);
                #1;
                drive(which, 1'b0, 0, 1'b0);
            end
        end
        e.cyc = cyc;
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
    endtask

    // Feeds chips that will be abandoned; nothing is expected from them.
    task automatic send_partial(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            drive(which, 1'b1, 1, 1'b0);
            @(posedge clk);
            #1;
        end
        drive(which, 1'b0, 0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_sym_valid"}, int'(bus_a.sym_valid), 0);
        check({tag, "_a_symbol"},    int'(bus_a.symbol), 0);
        check({tag, "_a_peak"},      int'(bus_a.peak_value), 0);
        check({tag, "_a_unmet"},     int'(bus_a.threshold_unmet), 0);
        check({tag, "_a_tie"},       int'(bus_a.tie), 0);
        check({tag, "_b_sym_valid"}, int'(bus_b.sym_valid), 0);
        check({tag, "_b_symbol"},    int'(bus_b.symbol), 0);
        check({tag, "_b_peak"},      int'(bus_b.peak_value), 0);
        check({tag, "_b_unmet"},     int'(bus_b.threshold_unmet), 0);
        check({tag, "_b_tie"},       int'(bus_b.tie), 0);
    endtask

    always @(negedge clk) begin
        if (bus_a.sym_valid) begin
            if (q_a.size() == 0) begin
                check("a_spurious_pulse", 1, 0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_symbol",  int'(bus_a.symbol), e.symbol);
                check("a_peak",    int'(bus_a.peak_value), e.peak);
                check("a_unmet",   int'(bus_a.threshold_unmet), e.unmet);
                check("a_tie",     int'(bus_a.tie), e.tie);
                check("a_latency", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.sym_valid) begin
            if (q_b.size() == 0) begin
                check("b_spurious_pulse", 1, 0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_symbol",  int'(bus_b.symbol), e.symbol);
                check("b_peak",    int'(bus_b.peak_value), e.peak);
                check("b_unmet",   int'(bus_b.threshold_unmet), e.unmet);
                check("b_tie",     int'(bus_b.tie), e.tie);
                check("b_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 0, 1'b0);
        drive(1, 1'b0, 0, 1'b0);
        bus_a.corr_threshold = '0;
        bus_b.corr_threshold = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // single hit on slot 5
        clear_stim();
        stim[0][5] = 1;
        send(0, 1, 1, 0, 1'b0);

        // all zero: full tie, highest index, threshold unmet
        clear_stim();
        send(0, 1, 1, 0, 1'b0);

        // two-way tie between slots 3 and 11
        clear_stim();
        stim[0][3]  = 1;
        stim[0][11] = 1;
        send(0, 1, 1, 0, 1'b0);

        // four-rep accumulation: slot 9 = 12, slot 2 = 11
        clear_stim();
        for (int r = 0; r < 4; r++) begin
            stim[r][9] = 3;
            stim[r][2] = (r == 3) ? 2 : 3;
        end
        send(1, 4, 12, 0, 1'b0);
        send(1, 4, 13, 0, 1'b0);

        // same symbol with random stalls
        for (int i = 0; i < 3; i++) send(1, 4, 12, 5, 1'b0);

        // random data with random stalls
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 4; r++)
                for (int s = 0; s < 16; s++)
                    stim[r][s] = int'($urandom_range(0, 3));
            send(1, 4, int'($urandom_range(0, 15)), 5, 1'b0);
        end

        // frame_start alone aborts a partial symbol
        clear_stim();
        stim[0][2] = 1;
        send_partial(0, 7);
        drive(0, 1'b0, 0, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 0, 1'b0);
        send(0, 1, 1, 0, 1'b0);

        // frame_start coincident with the first chip of the clean symbol
        send_partial(0, 7);
        send(0, 1, 1, 0, 1'b1);

        // same on the accumulating instance, aborted in its second rep
        clear_stim();
        for (int r = 0; r < 4; r++) begin
            stim[r][9] = 3;
            stim[r][2] = (r == 3) ? 2 : 3;
        end
        send_partial(1, 20);
        send(1, 4, 12, 0, 1'b1);

        // reset mid-symbol
        send_partial(0, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("mid_reset");

        // three back-to-back symbols
        clear_stim();
        stim[0][0] = 1;
        send(0, 1, 1, 0, 1'b0);
        clear_stim();
        stim[0][15] = 1;
        send(0, 1, 1, 0, 1'b0);
        clear_stim();
        stim[0][8] = 1;
        send(0, 1, 1, 0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("a_pending", q_a.size(), 0);
        check("b_pending", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ppm_accum_correlator.md
# ppm_accum_correlator

Sequential, parametrised M-ary PPM demodulator. It takes one slot count per cycle from the SPAD chip counter and accumulates counts over REPS repeated frames of the same symbol. It tracks the peak slot in a running compare and emits one registered decision per symbol: index, peak value, threshold flag and tie flag. It sits between the per-slot chip counter and the symbol deframer, and replaces the combinational 16-PPM argmax with a streaming block that has configurable order, width and repetition.

## Interface
- `PPM_BITS`, default 4: log2 of PPM order. M = 2^PPM_BITS slots per frame.
- `CHIP_BITS`, default 1: width of one slot count.
- `REPS`, default 1: frames accumulated per symbol, ≥1.
- `ACC_BITS` (localparam): CHIP_BITS + clog2(REPS). REPS=1 gives CHIP_BITS.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `frame_start`  in  1: resynchronise; forces the slot and rep counters to 0.
- `chip_valid`  in  1: chip_in holds the count for the current slot.
- `chip_in`  in  CHIP_BITS: unsigned slot count.
- `corr_threshold`  in  ACC_BITS: unsigned minimum accumulated peak.
- `sym_valid`  out  1: one-cycle pulse; decision outputs are new.
- `symbol`  out  PPM_BITS: winning slot index.
- `peak_value`  out  ACC_BITS: accumulated count of the winning slot.
- `threshold_unmet`  out  1: peak_value < corr_threshold.
- `tie`  out  1: two or more slots share the peak.

## Operation
- Counters:
  - slot counter s counts 0..M-1 and wraps.
  - rep counter r counts 0..REPS-1 and advances when s wraps.
  - Both advance only on cycles with chip_valid=1. chip_valid=0 holds all state (stall).
- Accumulator array acc[M], ACC_BITS each. On a valid chip, sum = (r==0 ? 0 : acc[s]) + chip_in, and acc[s] <= sum.
  - r==0 overwrites, so acc needs no reset or clear between symbols.
  - sum cannot overflow by construction of ACC_BITS. No saturation logic.
- Running peak, final rep only (r==REPS-1):
  - s==0: best<=sum, idx<=0, tie_r<=0.
  - sum>best: best<=sum, idx<=s, tie_r<=0.
  - sum==best: idx<=s, tie_r<=1. The higher index wins ties.
  - sum<best: no change.
- Decision: on a valid chip with s==M-1 and r==REPS-1, the next edge registers:
  - symbol and peak_value from the compare that includes this chip;
  - tie from the same compare;
  - threshold_unmet = (peak < corr_threshold), with corr_threshold sampled at that edge;
  - sym_valid=1 for exactly one cycle.
- Decision outputs hold until the next decision.
- frame_start:
  - With chip_valid=1 in the same cycle: the chip is processed as s=0, r=0.
  - With chip_valid=0: counters go to 0 and no chip is consumed.
  - In both cases the partial symbol is discarded with no sym_valid and outputs held.
- No backpressure. Downstream must accept sym_valid unconditionally.

## Timing
- Reset: s=0, r=0, sym_valid=0, symbol=0, peak_value=0, threshold_unmet=0, tie=0. Running peak state is cleared. acc contents are don't-care.
- rst has priority over frame_start and chip_valid in the same cycle.
- Latency: sym_valid rises 1 cycle after the edge sampling the final chip (chip M·REPS).
- Throughput: 1 chip/cycle sustained. Back-to-back symbols need no gap; s=0 of the next symbol may arrive in the cycle sym_valid is high.
- Stalls of any length, anywhere, including directly before the final chip, do not change results. They only delay sym_valid.
- Reset mid-symbol discards the partial symbol. The next valid chip is s=0, r=0.
- REPS=1: every frame yields a decision.
- Critical path: one ACC_BITS adder plus one ACC_BITS comparator. No M-wide combinational tree.

## Test plan
1. M=16, C=1, REPS=1, thr=1: 16 valid chips, only slot 5 =1.
   - sym_valid one cycle after the 16th chip.
   - symbol=5, peak=1, unmet=0, tie=0.
2. Same configuration, all chips 0, thr=1: symbol=15, peak=0, unmet=1, tie=1. Then slots 3 and 11 =1: symbol=11, tie=1.
3. M=16, C=2, REPS=4 (ACC_BITS=4), thr=12:
   - Slot 9 gets 3 every rep (12) and slot 2 gets 3,3,3,2 (11) → symbol=9, peak=12, unmet=0.
   - Rerun with thr=13 → unmet=1.
4. Random chip_valid gaps, 0–5 cycles, over case 3: identical outputs. sym_valid exactly 1 cycle after the last valid chip. Exactly one pulse per symbol.
5. frame_start at s=7 of a symbol, then 16 clean chips with slot 2 peak: no pulse for the aborted symbol, then symbol=2. Repeat with frame_start coincident with chip_valid=1.
6. rst asserted mid-symbol: all outputs equal reset values next cycle. Then 3 back-to-back symbols (slots 0, 15, 8) with no gaps: 3 pulses exactly 16 cycles apart with the correct symbols.
